// File: rtl/add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// the rule that turns operand width and digit size into a digit count.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter needs at least one bit even when a single digit covers the word.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the top
// bit so the caller can form signed overflow on the final digit.
module fa_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]  = x[i] ^ y[i] ^ cy[i];
      cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = cy[DIGIT];
  assign c_msb_in = cy[DIGIT-1];

endmodule

// File: rtl/add_sub_serial.sv
// Digit-serial add/subtract: operands are shifted out LSB digit first through
// one fa_digit, the result is assembled by shifting digits in from the top.
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);

  state_e state, nxt;

  logic [WIDTH-1:0] opa, opb, res_nxt;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dmsb;
  logic             last, accept;

  assign last   = (cnt == CW'(NDIG - 1));
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  fa_digit #(.DIGIT(DIGIT)) u_fa (
    .x        (opa[DIGIT-1:0]),
    .y        (opb[DIGIT-1:0]),
    .cin      (cy),
    .sum      (dsum),
    .cout     (dcout),
    .c_msb_in (dmsb)
  );

  // Upper part of the partial result; absent when one digit spans the word.
  generate
    if (NDIG == 1) begin : g_one
      assign res_nxt = dsum;
    end else begin : g_acc
      logic [WIDTH-DIGIT-1:0] acc;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              acc <= '0;
        else if (state == RUN)   acc <= res_nxt[WIDTH-1:DIGIT];
      end
      assign res_nxt = {dsum, acc};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      cy  <= 1'b0;
      cnt <= '0;
      s   <= '0;
      c   <= 1'b0;
      v   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b here, carry-in supplies the +1.
      opa <= a;
      opb <= b ^ {WIDTH{sub}};
      cy  <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= opa >> DIGIT;
      opb <= opb >> DIGIT;
      cy  <= dcout;
      cnt <= cnt + 1'b1;
      if (last) begin
        s <= res_nxt;
        c <= dcout;
        v <= dcout ^ dmsb;
      end
    end
  end

endmodule

// File: doc/add_sub_serial.md
ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, DIGIT >= 1.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled on rising clk edge.
REQ-006 sub  input  1  mode; 0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse: result valid.
REQ-011 s  output  WIDTH  sum/difference, registered.
REQ-012 c  output  1  carry-out (add) / NOT borrow (sub), registered.
REQ-013 v  output  1  two's-complement signed overflow, registered.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE; NDIG = WIDTH/DIGIT.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b XOR {WIDTH{sub}}, carry-in = sub, clear digit counter, enter RUN.
REQ-016 RUN: each edge SHALL add one DIGIT-bit slice (LSB slice first) plus stored carry, store slice result and carry-out, increment counter.
REQ-017 After the NDIG-th RUN edge the FSM SHALL enter DONE and load s, c, v from the completed result in the same edge.
REQ-018 Latency: start sampled at edge k -> done high during the cycle following edge k+NDIG, for exactly one cycle.
REQ-019 busy SHALL be high in RUN only; busy and done SHALL never be high together.
REQ-020 start while busy SHALL be ignored; operands and mode SHALL not change mid-operation.
REQ-021 DONE SHALL last one cycle; start=1 in DONE SHALL be accepted as in IDLE (back-to-back), else return to IDLE.
REQ-022 s, c, v SHALL hold their value from completion until the next completion; they SHALL not change during RUN.
REQ-023 v SHALL equal carry into MSB XOR carry out of MSB of the full WIDTH-bit operation.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-025 DIGIT = WIDTH SHALL give NDIG = 1 (one RUN cycle).

Reset
REQ-026 rst_n=0 SHALL immediately force FSM to IDLE, busy=0, done=0, s=0, c=0, v=0, counter and internal operands to 0.
REQ-027 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow deassertion.
REQ-028 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package add_sub_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the NDIG derivation rule.
REQ-030 One sub-module fa_digit SHALL implement the combinational DIGIT-bit ripple adder (inputs x, y, cin; outputs sum, cout, c_msb_in for overflow).
REQ-031 Total RTL SHALL be 120-400 lines; no multipliers, no vendor primitives.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-032 a=0x8000, b=0x8000, sub=0 -> s=0x0000, c=1, v=1; done exactly 4 cycles after start edge.
REQ-033 a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, c=0, v=0.
REQ-034 a=0x7FFF, b=0x0001, sub=0 -> s=0x8000, c=0, v=1; second start at cycle 2 ignored, s/c/v unchanged until done.
REQ-035 rst_n pulled low in 2nd RUN cycle -> all outputs 0 at once, no done pulse after release; next op correct.
REQ-036 WIDTH=4, DIGIT=4: a=8, b=12 -> s=4, c=1, v=1, 1-cycle latency; a=15, b=15 -> s=14, c=1, v=0.
REQ-037 Back-to-back: start held high across DONE -> second op accepted in DONE cycle, two done pulses spaced NDIG+1 cycles.
